universal_shift_register: RTL and testbench

Parametrised WIDTH-bit register with synchronous reset/preset, clock enable and four operating modes (hold, shift right, shift left, parallel load). An optional rotate mode and a shift counter with a completion pulse let it act as a serialiser/deserialiser. It is the multi-bit successor to the single-bit D flip-flop primitive and is intended as the storage/serial-conversion element in datapaths and serial links.

---
 rtl/usr_pkg.sv | 17 +
 rtl/usr_bit_cell.sv | 46 ++++
 rtl/universal_shift_register.sv | 103 ++++++++++
 tb/tb_universal_shift_register.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the helper that sizes the shift counter.
package usr_pkg;

  typedef logic [1:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 2'b00;
  localparam usr_mode_t MODE_SHR  = 2'b01;
  localparam usr_mode_t MODE_SHL  = 2'b10;
  localparam usr_mode_t MODE_LOAD = 2'b11;

  // Bits needed to hold a count from 0 up to and including width.
  function automatic int unsigned usr_count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: a 4:1 next-state mux feeding a
// flip-flop with synchronous reset, preset and clock enable.
module usr_bit_cell
  import usr_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic      clock_pos,
  input  logic      reset_neg,
  input  logic      preset_neg,
  input  logic      enable,
  input  usr_mode_t mode,
  input  logic      from_left,
  input  logic      from_right,
  input  logic      parallel_bit,
  output logic      bit_out
);

  logic bit_d;
  logic bit_q;

  // Next-state select: keep, take upper neighbour, take lower neighbour, or load.
  always_comb begin
    bit_d = bit_q;
    unique case (mode)
      MODE_HOLD: bit_d = bit_q;
      MODE_SHR:  bit_d = from_left;
      MODE_SHL:  bit_d = from_right;
      MODE_LOAD: bit_d = parallel_bit;
    endcase
  end

  // Storage flop; reset beats preset, preset beats the enable gate.
  always_ff @(posedge clock_pos) begin
    if (!reset_neg) begin
      bit_q <= RESET_BIT;
    end else if (!preset_neg) begin
      bit_q <= 1'b1;
    end else if (enable) begin
      bit_q <= bit_d;
    end
  end

  assign bit_out = bit_q;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with hold / shift right / shift left /
// parallel load, optional rotation, and a saturating shift counter that
// pulses shift_done when the WIDTH-th shift since the last load completes.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter bit               ROTATE      = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                 clock_pos,
  input  logic                                 reset_neg,
  input  logic                                 preset_neg,
  input  logic                                 enable,
  input  logic [1:0]                           mode,
  input  logic                                 serial_in_left,
  input  logic                                 serial_in_right,
  input  logic [WIDTH-1:0]                     parallel_in,
  output logic [WIDTH-1:0]                     signal_out,
  output logic [WIDTH-1:0]                     signal_out_neg,
  output logic                                 serial_out_left,
  output logic                                 serial_out_right,
  output logic [usr_count_width(WIDTH)-1:0]    shift_count,
  output logic                                 shift_done
);

  localparam int unsigned CW = usr_count_width(WIDTH);
  localparam logic [CW-1:0] CountFull = CW'(WIDTH);

  logic [WIDTH-1:0] data;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic from_left;
    logic from_right;

    // MSB takes the serial input, or wraps from the LSB when rotating.
    if (i == WIDTH - 1) begin : g_msb
      assign from_left = ROTATE ? data[0] : serial_in_left;
    end else begin : g_mid_l
      assign from_left = data[i+1];
    end

    // LSB takes the serial input, or wraps from the MSB when rotating.
    if (i == 0) begin : g_lsb
      assign from_right = ROTATE ? data[WIDTH-1] : serial_in_right;
    end else begin : g_mid_r
      assign from_right = data[i-1];
    end

    usr_bit_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .clock_pos    (clock_pos),
      .reset_neg    (reset_neg),
      .preset_neg   (preset_neg),
      .enable       (enable),
      .mode         (mode),
      .from_left    (from_left),
      .from_right   (from_right),
      .parallel_bit (parallel_in[i]),
      .bit_out      (data[i])
    );
  end

  logic [CW-1:0] count_d, count_q;
  logic          done_d, done_q;
  logic          is_shift;

  assign is_shift = enable && ((mode == MODE_SHR) || (mode == MODE_SHL));

  // Counter next state; shift_done is a pulse so it defaults low every edge.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (!preset_neg) begin
      count_d = '0;
    end else if (enable && (mode == MODE_LOAD)) begin
      count_d = '0;
    end else if (is_shift && (count_q < CountFull)) begin
      count_d = count_q + CW'(1);
      done_d  = (count_d == CountFull);
    end
  end

  // Counter and pulse registers with synchronous active-low reset.
  always_ff @(posedge clock_pos) begin
    if (!reset_neg) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign signal_out       = data;
  assign signal_out_neg   = ~data;
  assign serial_out_left  = data[WIDTH-1];
  assign serial_out_right = data[0];
  assign shift_count      = count_q;
  assign shift_done       = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  logic       clock_pos = 1'b0;
  logic       reset_neg = 1'b0;
  logic       preset_neg = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       serial_in_left = 1'b0;
  logic       serial_in_right = 1'b0;
  logic [7:0] parallel_in = 8'h00;

  logic [7:0] out0, neg0, out1, neg1;
  logic       sol0, sor0, sol1, sor1, done0, done1;
  logic [3:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: index 0 = shifting DUT, index 1 = rotating DUT.
  logic [7:0] m_val [2];
  int         m_cnt [2];
  bit         m_done[2];

  always #5 clock_pos = ~clock_pos;

  universal_shift_register #(
    .WIDTH (8), .ROTATE (1'b0), .RESET_VALUE (8'hA5)
  ) u_dut_shift (
    .clock_pos (clock_pos), .reset_neg (reset_neg), .preset_neg (preset_neg),
    .enable (enable), .mode (mode), .serial_in_left (serial_in_left),
    .serial_in_right (serial_in_right), .parallel_in (parallel_in),
    .signal_out (out0), .signal_out_neg (neg0), .serial_out_left (sol0),
    .serial_out_right (sor0), .shift_count (cnt0), .shift_done (done0)
  );

  universal_shift_register #(
    .WIDTH (8), .ROTATE (1'b1), .RESET_VALUE (8'hA5)
  ) u_dut_rot (
    .clock_pos (clock_pos), .reset_neg (reset_neg), .preset_neg (preset_neg),
    .enable (enable), .mode (mode), .serial_in_left (serial_in_left),
    .serial_in_right (serial_in_right), .parallel_in (parallel_in),
    .signal_out (out1), .signal_out_neg (neg1), .serial_out_left (sol1),
    .serial_out_right (sor1), .shift_count (cnt1), .shift_done (done1)
  );

  // Behavioural model of one register for one clock edge, using plain arithmetic.
  task automatic model_one(input int k, input bit rot);
    int v;
    int in_bit;
    bit shifted;
    v = int'(m_val[k]);
    shifted = 1'b0;
    if (!reset_neg) begin
      v = 'hA5; m_cnt[k] = 0; m_done[k] = 0;
    end else if (!preset_neg) begin
      v = 255; m_cnt[k] = 0; m_done[k] = 0;
    end else if (!enable || mode == 2'd0) begin
      m_done[k] = 0;
    end else if (mode == 2'd1) begin
      in_bit = rot ? (v % 2) : int'(serial_in_left);
      v = (v / 2) + in_bit * 128;
      shifted = 1'b1;
    end else if (mode == 2'd2) begin
      in_bit = rot ? (v / 128) : int'(serial_in_right);
      v = ((v * 2) % 256) + in_bit;
      shifted = 1'b1;
    end else begin
      v = int'(parallel_in); m_cnt[k] = 0; m_done[k] = 0;
    end
    if (shifted) begin
      if (m_cnt[k] < 8) begin
        m_cnt[k] = m_cnt[k] + 1;
        m_done[k] = (m_cnt[k] == 8);
      end else begin
        m_done[k] = 0;
      end
    end
    m_val[k] = v[7:0];
  endtask

  // Advance both models and the DUTs by one rising edge; sample 1 ns later.
  task automatic step();
    model_one(0, 1'b0);
    model_one(1, 1'b1);
    @(posedge clock_pos);
    #1;
  endtask

  task automatic drive(input bit rn, input bit pn, input bit en, input logic [1:0] md);
    reset_neg = rn; preset_neg = pn; enable = en; mode = md;
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 2'b11);
    parallel_in = 8'hFF;
    step();
    step();
    n_checks++;
    if (out0 !== 8'hA5) begin n_errors++; $display("FAIL reset_out: got %h want a5", out0); end
    n_checks++;
    if (neg0 !== 8'h5A) begin n_errors++; $display("FAIL reset_neg_out: got %h want 5a", neg0); end
    n_checks++;
    if (cnt0 !== 4'd0 || done0 !== 1'b0) begin
      n_errors++; $display("FAIL reset_count: got cnt=%0d done=%b want 0 0", cnt0, done0);
    end
    n_checks++;
    if (sol0 !== 1'b1 || sor0 !== 1'b1) begin
      n_errors++; $display("FAIL reset_serial: got l=%b r=%b want 1 1", sol0, sor0);
    end
    n_checks++;
    if (out1 !== 8'hA5) begin n_errors++; $display("FAIL reset_out_rot: got %h want a5", out1); end
  endtask

  task automatic test_shift_right();
    logic [7:0] exp_bits;
    exp_bits = 8'b1000_0001;
    drive(1, 1, 1, 2'b11);
    parallel_in = 8'h81;
    step();
    serial_in_left = 1'b0;
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (sor0 !== exp_bits[i]) begin
        n_errors++; $display("FAIL shr_serial_out[%0d]: got %b want %b", i, sor0, exp_bits[i]);
      end
      step();
      n_checks++;
      if (cnt0 !== 4'(i + 1) || done0 !== (i == 7)) begin
        n_errors++;
        $display("FAIL shr_count[%0d]: got cnt=%0d done=%b want %0d %b", i, cnt0, done0, i + 1,
                 i == 7);
      end
    end
    step();
    n_checks++;
    if (cnt0 !== 4'd8 || done0 !== 1'b0) begin
      n_errors++; $display("FAIL shr_saturate: got cnt=%0d done=%b want 8 0", cnt0, done0);
    end
    n_checks++;
    if (out0 !== 8'h00) begin n_errors++; $display("FAIL shr_data: got %h want 00", out0); end
  endtask

  task automatic test_rotate();
    int pulses;
    drive(1, 1, 1, 2'b11);
    parallel_in = 8'h01;
    step();
    serial_in_right = 1'b1;
    mode = 2'b10;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done1 === 1'b1) pulses++;
    end
    n_checks++;
    if (out1 !== 8'h08) begin n_errors++; $display("FAIL rot_three: got %h want 08", out1); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (done1 === 1'b1) pulses++;
    end
    n_checks++;
    if (out1 !== 8'h01) begin n_errors++; $display("FAIL rot_full: got %h want 01", out1); end
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("FAIL rot_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_priority();
    drive(1, 1, 1, 2'b01);
    step();
    step();
    step();
    // Preset together with load: preset wins and the count clears.
    drive(1, 0, 1, 2'b11);
    parallel_in = 8'h3C;
    step();
    n_checks++;
    if (out0 !== 8'hFF || cnt0 !== 4'd0) begin
      n_errors++; $display("FAIL preset_over_load: got %h cnt=%0d want ff 0", out0, cnt0);
    end
    drive(0, 0, 0, 2'b11);
    step();
    n_checks++;
    if (out0 !== 8'hA5) begin n_errors++; $display("FAIL reset_over_preset: got %h want a5", out0); end
    drive(1, 0, 1, 2'b11);
    step();
    n_checks++;
    if (out0 !== 8'hFF || cnt0 !== 4'd0) begin
      n_errors++; $display("FAIL preset_only: got %h cnt=%0d want ff 0", out0, cnt0);
    end
  endtask

  task automatic test_enable();
    logic [7:0] held;
    drive(1, 1, 1, 2'b11);
    parallel_in = 8'h5B;
    step();
    mode = 2'b01;
    serial_in_left = 1'b1;
    step(); step(); step();
    held = m_val[0];
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (out0 !== held || cnt0 !== 4'd3 || done0 !== 1'b0) begin
        n_errors++;
        $display("FAIL enable_hold[%0d]: got %h cnt=%0d done=%b want %h 3 0", i, out0, cnt0,
                 done0, held);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (cnt0 !== 4'(4 + i) || done0 !== (i == 4)) begin
        n_errors++;
        $display("FAIL enable_resume[%0d]: got cnt=%0d done=%b want %0d %b", i, cnt0, done0,
                 4 + i, i == 4);
      end
    end
  endtask

  task automatic test_abort();
    drive(1, 1, 1, 2'b11);
    parallel_in = 8'hC3;
    step();
    mode = 2'b10;
    for (int i = 0; i < 4; i++) step();
    reset_neg = 1'b0;
    step();
    n_checks++;
    if (cnt0 !== 4'd0 || out0 !== 8'hA5) begin
      n_errors++; $display("FAIL abort_reset: got %h cnt=%0d want a5 0", out0, cnt0);
    end
    reset_neg = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (done0 !== (i == 7)) begin
        n_errors++; $display("FAIL abort_done[%0d]: got %b want %b", i, done0, i == 7);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset_neg       = ($urandom_range(0, 29) != 0);
      preset_neg      = ($urandom_range(0, 24) != 0);
      enable          = ($urandom_range(0, 3) != 0);
      mode            = 2'($urandom_range(0, 3));
      serial_in_left  = 1'($urandom_range(0, 1));
      serial_in_right = 1'($urandom_range(0, 1));
      parallel_in     = 8'($urandom);
      step();
      n_checks++;
      if (out0 !== m_val[0] || neg0 !== ~m_val[0] || sol0 !== m_val[0][7] ||
          sor0 !== m_val[0][0] || cnt0 !== 4'(m_cnt[0]) || done0 !== m_done[0]) begin
        n_errors++;
        $display("FAIL rand_shift[%0d]: got %h/%h %b%b cnt=%0d done=%b want %h cnt=%0d done=%b",
                 i, out0, neg0, sol0, sor0, cnt0, done0, m_val[0], m_cnt[0], m_done[0]);
      end
      n_checks++;
      if (out1 !== m_val[1] || neg1 !== ~m_val[1] || sol1 !== m_val[1][7] ||
          sor1 !== m_val[1][0] || cnt1 !== 4'(m_cnt[1]) || done1 !== m_done[1]) begin
        n_errors++;
        $display("FAIL rand_rot[%0d]: got %h/%h %b%b cnt=%0d done=%b want %h cnt=%0d done=%b",
                 i, out1, neg1, sol1, sor1, cnt1, done1, m_val[1], m_cnt[1], m_done[1]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 8'h00; m_cnt[k] = 0; m_done[k] = 1'b0;
    end
    test_reset();
    test_shift_right();
    test_rotate();
    test_priority();
    test_enable();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
